// File: rtl/rob_commit_if.sv
// Allocation, completion and retirement signals between the front end and the reorder buffer.
interface rob_commit_if #(
    parameter int unsigned FETCH_WIDTH  = 4,
    parameter int unsigned RETIRE_WIDTH = 3,
    parameter int unsigned WB_PORTS     = 2
);
    logic [FETCH_WIDTH-1:0]       alloc_valid;
    logic [8*FETCH_WIDTH-1:0]     alloc_arch_regs;
    logic [10*FETCH_WIDTH-1:0]    alloc_old_aliases;
    logic                         alloc_ready;
    logic [5*FETCH_WIDTH-1:0]     ROB_entries;
    logic [WB_PORTS-1:0]          wb_valid;
    logic [5*WB_PORTS-1:0]        wb_entry;
    logic [RETIRE_WIDTH-1:0]      retire_valid;
    logic [10*RETIRE_WIDTH-1:0]   cmplt_free_regs;
    logic [8*RETIRE_WIDTH-1:0]    cmplt_dest_regs;
    logic [5:0]                   rob_count;

    modport master (
        output alloc_valid, alloc_arch_regs, alloc_old_aliases, wb_valid, wb_entry,
        input  alloc_ready, ROB_entries, retire_valid, cmplt_free_regs, cmplt_dest_regs, rob_count
    );

    modport slave (
        input  alloc_valid, alloc_arch_regs, alloc_old_aliases, wb_valid, wb_entry,
        output alloc_ready, ROB_entries, retire_valid, cmplt_free_regs, cmplt_dest_regs, rob_count
    );
endinterface

// File: rtl/rob_commit.sv
// 32-entry reorder buffer: in-order allocation, out-of-order completion, in-order
// retirement of up to RETIRE_WIDTH ops per cycle with registered retire outputs.
module rob_commit #(
    parameter int unsigned FETCH_WIDTH  = 4,
    parameter int unsigned RETIRE_WIDTH = 3,
    parameter int unsigned ROB_DEPTH    = 32,
    parameter int unsigned WB_PORTS     = 2
) (
    input  logic        clk,
    input  logic        rst,
    rob_commit_if.slave rob
);
    localparam int unsigned IDX_W = 5;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned ENTRIES = 32;

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [ENTRIES-1:0] done;
    logic [7:0] arch_mem  [ENTRIES];
    logic [9:0] alias_mem [ENTRIES];

    logic [CNT_W-1:0] alloc_n;
    logic [CNT_W-1:0] ret_n;
    logic             alloc_ready_c;
    logic [5*FETCH_WIDTH-1:0]   entries_c;
    logic [RETIRE_WIDTH-1:0]    retire_valid_q;
    logic [10*RETIRE_WIDTH-1:0] free_regs_q;
    logic [8*RETIRE_WIDTH-1:0]  dest_regs_q;

    // Entry e is live when its distance from head is below the occupancy count.
    function automatic logic is_occupied(input logic [IDX_W-1:0] e,
                                         input logic [IDX_W-1:0] h,
                                         input logic [CNT_W-1:0] c);
        return {1'b0, IDX_W'(e - h)} < c;
    endfunction

    always_comb begin
        alloc_ready_c = !rst && (count <= CNT_W'(ROB_DEPTH - FETCH_WIDTH));
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            entries_c[i*5 +: 5] = IDX_W'(tail + IDX_W'(i));
        end
    end

    // Allocation takes the contiguous run of valid lanes starting at lane 0.
    always_comb begin
        logic run;
        alloc_n = '0;
        run     = alloc_ready_c;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (run && rob.alloc_valid[i]) begin
                alloc_n = alloc_n + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Retire walk: consecutive occupied, done entries from head, using pre-edge done bits.
    always_comb begin
        logic             run;
        logic [IDX_W-1:0] idx;
        ret_n = '0;
        run   = 1'b1;
        idx   = head;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            idx = IDX_W'(head + IDX_W'(k));
            if (run && (CNT_W'(k) < count) && done[idx]) begin
                ret_n = ret_n + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            done           <= '0;
            retire_valid_q <= '0;
            free_regs_q    <= '0;
            dest_regs_q    <= '0;
        end else begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (rob.wb_valid[p] && is_occupied(rob.wb_entry[p*5 +: 5], head, count)) begin
                    done[rob.wb_entry[p*5 +: 5]] <= 1'b1;
                end
            end
            for (int k = 0; k < RETIRE_WIDTH; k++) begin
                if (CNT_W'(k) < ret_n) begin
                    done[IDX_W'(head + IDX_W'(k))]  <= 1'b0;
                    retire_valid_q[k]               <= 1'b1;
                    free_regs_q[k*10 +: 10]         <= alias_mem[IDX_W'(head + IDX_W'(k))];
                    dest_regs_q[k*8 +: 8]           <= arch_mem[IDX_W'(head + IDX_W'(k))];
                end else begin
                    retire_valid_q[k]       <= 1'b0;
                    free_regs_q[k*10 +: 10] <= '0;
                    dest_regs_q[k*8 +: 8]   <= '0;
                end
            end
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (CNT_W'(i) < alloc_n) begin
                    done[IDX_W'(tail + IDX_W'(i))]      <= 1'b0;
                    arch_mem[IDX_W'(tail + IDX_W'(i))]  <= rob.alloc_arch_regs[i*8 +: 8];
                    alias_mem[IDX_W'(tail + IDX_W'(i))] <= rob.alloc_old_aliases[i*10 +: 10];
                end
            end
            head  <= IDX_W'(head + IDX_W'(ret_n));
            tail  <= IDX_W'(tail + IDX_W'(alloc_n));
            count <= count + alloc_n - ret_n;
        end
    end

    assign rob.alloc_ready     = alloc_ready_c;
    assign rob.ROB_entries     = entries_c;
    assign rob.retire_valid    = retire_valid_q;
    assign rob.cmplt_free_regs = free_regs_q;
    assign rob.cmplt_dest_regs = dest_regs_q;
    assign rob.rob_count       = count;
endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus randomized traffic against a queue-based model.
module tb_rob_commit;
    logic clk;
    logic rst;
    int   nchecks;
    int   nerr;

    rob_commit_if #(.FETCH_WIDTH(4), .RETIRE_WIDTH(3), .WB_PORTS(2)) bus ();

    rob_commit #(.FETCH_WIDTH(4), .RETIRE_WIDTH(3), .ROB_DEPTH(32), .WB_PORTS(2)) dut (
        .clk(clk),
        .rst(rst),
        .rob(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] arch;
        logic [9:0] alias_v;
        bit         done;
    } ent_t;

    ent_t        q[$];
    int          m_head;
    int          m_tail;
    logic [2:0]  exp_rv;
    logic [29:0] exp_free;
    logic [23:0] exp_dest;

    // Advance one clock edge and move the model by the ROB's rules.
    task automatic tick();
        int   r;
        int   n;
        int   off;
        bit   ready;
        ent_t e;
        r = 0;
        while (r < 3 && r < q.size() && q[r].done) r++;
        ready = (rst == 1'b0) && (q.size() <= 28);
        n = 0;
        if (ready) while (n < 4 && bus.alloc_valid[n]) n++;
        if (rst) begin
            q.delete();
            m_head = 0;
            m_tail = 0;
            exp_rv = '0; exp_free = '0; exp_dest = '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (bus.wb_valid[p]) begin
                    off = (int'(bus.wb_entry[p*5 +: 5]) - m_head + 32) % 32;
                    if (off < q.size()) begin
                        e = q[off];
                        e.done = 1'b1;
                        q[off] = e;
                    end
                end
            end
            exp_rv = '0; exp_free = '0; exp_dest = '0;
            for (int k = 0; k < r; k++) begin
                e = q.pop_front();
                exp_rv[k] = 1'b1;
                exp_free[k*10 +: 10] = e.alias_v;
                exp_dest[k*8 +: 8]   = e.arch;
            end
            m_head = (m_head + r) % 32;
            for (int i = 0; i < n; i++) begin
                e.idx     = m_tail;
                e.arch    = bus.alloc_arch_regs[i*8 +: 8];
                e.alias_v = bus.alloc_old_aliases[i*10 +: 10];
                e.done    = 1'b0;
                q.push_back(e);
                m_tail = (m_tail + 1) % 32;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Drive completions for up to two oldest pending entries.
    task automatic drive_wb_oldest();
        int c;
        c = 0;
        bus.wb_valid = '0;
        bus.wb_entry = '0;
        for (int k = 0; k < q.size(); k++) begin
            if (!q[k].done && c < 2) begin
                bus.wb_entry[c*5 +: 5] = 5'(q[k].idx);
                bus.wb_valid[c] = 1'b1;
                c++;
            end
        end
    endtask

    task automatic idle_inputs();
        bus.alloc_valid       = '0;
        bus.alloc_arch_regs   = '0;
        bus.alloc_old_aliases = '0;
        bus.wb_valid          = '0;
        bus.wb_entry          = '0;
    endtask

    task automatic test_reset();
        logic [19:0] ent0;
        rst = 1'b1;
        idle_inputs();
        #1;
        nchecks++;
        if (bus.alloc_ready !== 1'b0) begin
            nerr++; $display("FAIL reset_ready: got %b expected 0", bus.alloc_ready);
        end
        tick();
        tick();
        ent0 = {5'd3, 5'd2, 5'd1, 5'd0};
        nchecks++;
        if (bus.rob_count !== 6'd0) begin
            nerr++; $display("FAIL reset_count: got %0d expected 0", bus.rob_count);
        end
        nchecks++;
        if (bus.retire_valid !== 3'b000 || bus.cmplt_free_regs !== 30'd0 || bus.cmplt_dest_regs !== 24'd0) begin
            nerr++; $display("FAIL reset_retire: got rv=%b free=%h dest=%h expected zeros",
                             bus.retire_valid, bus.cmplt_free_regs, bus.cmplt_dest_regs);
        end
        nchecks++;
        if (bus.ROB_entries !== ent0) begin
            nerr++; $display("FAIL reset_entries: got %h expected %h", bus.ROB_entries, ent0);
        end
        rst = 1'b0;
        #1;
        nchecks++;
        if (bus.alloc_ready !== 1'b1) begin
            nerr++; $display("FAIL ready_after_reset: got %b expected 1", bus.alloc_ready);
        end
    endtask

    task automatic test_directed();
        bus.alloc_valid       = 4'b1111;
        bus.alloc_arch_regs   = {8'd3, 8'd2, 8'd1, 8'd0};
        bus.alloc_old_aliases = {10'h203, 10'h202, 10'h201, 10'h200};
        tick();
        idle_inputs();
        nchecks++;
        if (bus.rob_count !== 6'd4 || bus.ROB_entries !== {5'd7, 5'd6, 5'd5, 5'd4}) begin
            nerr++; $display("FAIL first_alloc: got count=%0d entries=%h expected 4 / %h",
                             bus.rob_count, bus.ROB_entries, {5'd7, 5'd6, 5'd5, 5'd4});
        end
        bus.wb_valid = 2'b11;
        bus.wb_entry = {5'd0, 5'd1};
        tick();
        idle_inputs();
        tick();
        nchecks++;
        if (bus.retire_valid !== 3'b011 || bus.cmplt_free_regs !== {10'h0, 10'h201, 10'h200}
            || bus.cmplt_dest_regs !== {8'h0, 8'h01, 8'h00} || bus.rob_count !== 6'd2) begin
            nerr++; $display("FAIL retire_01: got rv=%b free=%h dest=%h count=%0d",
                             bus.retire_valid, bus.cmplt_free_regs, bus.cmplt_dest_regs, bus.rob_count);
        end
        bus.wb_valid = 2'b01;
        bus.wb_entry = {5'd0, 5'd3};
        tick();
        idle_inputs();
        tick();
        nchecks++;
        if (bus.retire_valid !== 3'b000 || bus.rob_count !== 6'd2) begin
            nerr++; $display("FAIL head_pending: got rv=%b count=%0d expected 000 / 2",
                             bus.retire_valid, bus.rob_count);
        end
        bus.wb_valid = 2'b10;
        bus.wb_entry = {5'd2, 5'd0};
        tick();
        idle_inputs();
        tick();
        nchecks++;
        if (bus.retire_valid !== 3'b011 || bus.cmplt_free_regs !== {10'h0, 10'h203, 10'h202}
            || bus.cmplt_dest_regs !== {8'h0, 8'h03, 8'h02} || bus.rob_count !== 6'd0) begin
            nerr++; $display("FAIL retire_23: got rv=%b free=%h dest=%h count=%0d",
                             bus.retire_valid, bus.cmplt_free_regs, bus.cmplt_dest_regs, bus.rob_count);
        end
        // Completion aimed at an entry allocated in the same cycle is dropped.
        bus.alloc_valid       = 4'b0001;
        bus.alloc_arch_regs   = {24'h0, 8'h44};
        bus.alloc_old_aliases = {30'h0, 10'h144};
        bus.wb_valid = 2'b01;
        bus.wb_entry = {5'd0, 5'd4};
        tick();
        idle_inputs();
        tick();
        tick();
        nchecks++;
        if (bus.retire_valid !== 3'b000 || bus.rob_count !== 6'd1) begin
            nerr++; $display("FAIL same_cycle_wb: got rv=%b count=%0d expected 000 / 1",
                             bus.retire_valid, bus.rob_count);
        end
        bus.wb_valid = 2'b01;
        bus.wb_entry = {5'd0, 5'd4};
        tick();
        idle_inputs();
        tick();
        nchecks++;
        if (bus.retire_valid !== 3'b001 || bus.cmplt_dest_regs !== 24'h000044
            || bus.cmplt_free_regs !== 30'h144 || bus.rob_count !== 6'd0) begin
            nerr++; $display("FAIL late_wb: got rv=%b dest=%h free=%h count=%0d",
                             bus.retire_valid, bus.cmplt_dest_regs, bus.cmplt_free_regs, bus.rob_count);
        end
    endtask

    task automatic test_full();
        int h;
        for (int c = 0; c < 7; c++) begin
            bus.alloc_valid       = 4'b1111;
            bus.alloc_arch_regs   = {$urandom, $urandom} & 32'hffff_ffff;
            bus.alloc_old_aliases = 40'({$urandom, $urandom});
            tick();
        end
        idle_inputs();
        #1;
        nchecks++;
        if (bus.rob_count !== 6'd28 || bus.alloc_ready !== 1'b1) begin
            nerr++; $display("FAIL count28: got count=%0d ready=%b expected 28 / 1",
                             bus.rob_count, bus.alloc_ready);
        end
        bus.alloc_valid = 4'b0001;
        tick();
        nchecks++;
        if (bus.rob_count !== 6'd29 || bus.alloc_ready !== 1'b0) begin
            nerr++; $display("FAIL count29: got count=%0d ready=%b expected 29 / 0",
                             bus.rob_count, bus.alloc_ready);
        end
        bus.alloc_valid = 4'b1111;
        h = m_head;
        bus.wb_valid = 2'b11;
        bus.wb_entry = {5'((h + 2) % 32), 5'((h + 1) % 32)};
        tick();
        nchecks++;
        if (bus.rob_count !== 6'd29) begin
            nerr++; $display("FAIL alloc_blocked: got count=%0d expected 29", bus.rob_count);
        end
        bus.wb_valid = 2'b01;
        bus.wb_entry = {5'd0, 5'(h)};
        tick();
        bus.wb_valid = 2'b00;
        tick();
        bus.alloc_valid = 4'b0000;
        #1;
        nchecks++;
        if (bus.retire_valid !== 3'b111 || bus.cmplt_dest_regs !== exp_dest
            || bus.cmplt_free_regs !== exp_free || bus.rob_count !== 6'd26 || bus.alloc_ready !== 1'b1) begin
            nerr++; $display("FAIL full_retire3: got rv=%b dest=%h free=%h count=%0d ready=%b expected 111 %h %h 26 1",
                             bus.retire_valid, bus.cmplt_dest_regs, bus.cmplt_free_regs,
                             bus.rob_count, bus.alloc_ready, exp_dest, exp_free);
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 40 && m_tail != 30; c++) begin
            bus.alloc_valid       = 4'b0011;
            bus.alloc_arch_regs   = 32'($urandom);
            bus.alloc_old_aliases = 40'({$urandom, $urandom});
            drive_wb_oldest();
            tick();
        end
        idle_inputs();
        #1;
        nchecks++;
        if (bus.ROB_entries !== {5'd1, 5'd0, 5'd31, 5'd30}) begin
            nerr++; $display("FAIL wrap_entries: got %h expected %h", bus.ROB_entries, {5'd1, 5'd0, 5'd31, 5'd30});
        end
        for (int c = 0; c < 60 && q.size() != 0; c++) begin
            drive_wb_oldest();
            tick();
        end
        idle_inputs();
        tick();
        nchecks++;
        if (bus.rob_count !== 6'd0) begin
            nerr++; $display("FAIL wrap_drain: got count=%0d expected 0", bus.rob_count);
        end
        bus.alloc_valid       = 4'b1111;
        bus.alloc_arch_regs   = {8'h83, 8'h82, 8'h81, 8'h80};
        bus.alloc_old_aliases = {10'h303, 10'h302, 10'h301, 10'h300};
        tick();
        bus.alloc_valid       = 4'b0001;
        bus.alloc_arch_regs   = {24'h0, 8'h84};
        bus.alloc_old_aliases = {30'h0, 10'h304};
        tick();
        idle_inputs();
        bus.wb_valid = 2'b11; bus.wb_entry = {5'd0, 5'd31};
        tick();
        bus.wb_valid = 2'b11; bus.wb_entry = {5'd2, 5'd1};
        tick();
        bus.wb_valid = 2'b01; bus.wb_entry = {5'd0, 5'd30};
        tick();
        idle_inputs();
        tick();
        nchecks++;
        if (bus.retire_valid !== 3'b111 || bus.cmplt_dest_regs !== {8'h82, 8'h81, 8'h80}
            || bus.cmplt_free_regs !== {10'h302, 10'h301, 10'h300}) begin
            nerr++; $display("FAIL wrap_retire3: got rv=%b dest=%h free=%h",
                             bus.retire_valid, bus.cmplt_dest_regs, bus.cmplt_free_regs);
        end
        tick();
        nchecks++;
        if (bus.retire_valid !== 3'b011 || bus.cmplt_dest_regs !== {8'h00, 8'h84, 8'h83}
            || bus.cmplt_free_regs !== {10'h000, 10'h304, 10'h303} || bus.rob_count !== 6'd0) begin
            nerr++; $display("FAIL wrap_retire2: got rv=%b dest=%h free=%h count=%0d",
                             bus.retire_valid, bus.cmplt_dest_regs, bus.cmplt_free_regs, bus.rob_count);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        bus.alloc_arch_regs   = 32'h0403_0201;
        bus.alloc_old_aliases = 40'h12_3456_789a;
        bus.alloc_valid = 4'b1111; tick();
        bus.alloc_valid = 4'b1111; tick();
        bus.alloc_valid = 4'b0011; tick();
        idle_inputs();
        bus.wb_valid = 2'b11; bus.wb_entry = {5'd2, 5'd1}; tick();
        bus.wb_valid = 2'b11; bus.wb_entry = {5'd4, 5'd3}; tick();
        idle_inputs();
        tick();
        nchecks++;
        if (bus.rob_count !== 6'd10 || bus.retire_valid !== 3'b000) begin
            nerr++; $display("FAIL mid_setup: got count=%0d rv=%b expected 10 / 000", bus.rob_count, bus.retire_valid);
        end
        rst = 1'b1;
        #1;
        nchecks++;
        if (bus.alloc_ready !== 1'b0) begin
            nerr++; $display("FAIL mid_ready: got %b expected 0", bus.alloc_ready);
        end
        tick();
        rst = 1'b0;
        nchecks++;
        if (bus.rob_count !== 6'd0 || bus.retire_valid !== 3'b000
            || bus.cmplt_free_regs !== 30'd0 || bus.cmplt_dest_regs !== 24'd0) begin
            nerr++; $display("FAIL mid_reset: got count=%0d rv=%b free=%h dest=%h",
                             bus.rob_count, bus.retire_valid, bus.cmplt_free_regs, bus.cmplt_dest_regs);
        end
        tick();
        nchecks++;
        if (bus.retire_valid !== 3'b000 || bus.rob_count !== 6'd0) begin
            nerr++; $display("FAIL mid_after: got rv=%b count=%0d expected 000 / 0", bus.retire_valid, bus.rob_count);
        end
    endtask

    task automatic test_random();
        logic [19:0] exp_ent;
        bit          exp_ready;
        for (int c = 0; c < 800; c++) begin
            rst = (($urandom % 150) == 0);
            bus.alloc_valid       = (($urandom % 3) == 0) ? 4'b1111 : 4'($urandom);
            bus.alloc_arch_regs   = 32'($urandom);
            bus.alloc_old_aliases = 40'({$urandom, $urandom});
            bus.wb_valid          = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                if (($urandom % 4) != 0 && q.size() > 0)
                    bus.wb_entry[p*5 +: 5] = 5'(q[$urandom % q.size()].idx);
                else
                    bus.wb_entry[p*5 +: 5] = 5'($urandom);
            end
            #1;
            exp_ready = (rst == 1'b0) && (q.size() <= 28);
            for (int i = 0; i < 4; i++) exp_ent[i*5 +: 5] = 5'((m_tail + i) % 32);
            nchecks++;
            if (bus.alloc_ready !== exp_ready || bus.ROB_entries !== exp_ent) begin
                nerr++; $display("FAIL rand_comb[%0d]: got ready=%b entries=%h expected %b %h",
                                 c, bus.alloc_ready, bus.ROB_entries, exp_ready, exp_ent);
            end
            tick();
            nchecks++;
            if (bus.rob_count !== 6'(q.size()) || bus.retire_valid !== exp_rv
                || bus.cmplt_free_regs !== exp_free || bus.cmplt_dest_regs !== exp_dest) begin
                nerr++; $display("FAIL rand_state[%0d]: got count=%0d rv=%b free=%h dest=%h expected %0d %b %h %h",
                                 c, bus.rob_count, bus.retire_valid, bus.cmplt_free_regs, bus.cmplt_dest_regs,
                                 q.size(), exp_rv, exp_free, exp_dest);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        nchecks = 0;
        nerr    = 0;
        m_head  = 0;
        m_tail  = 0;
        exp_rv = '0; exp_free = '0; exp_dest = '0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_directed();
        test_full();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", nchecks, nerr);
        $fatal(1);
    end
endmodule
